prio_encoder_rr: RTL and testbench

Parametrised, registered N-to-log2(N) priority encoder with a valid/ready output handshake and a selectable fixed-priority or round-robin search order. It is the successor to the 4-input, 2-bit-output combinational encoder. It registers its result, holds it stable under back-pressure, and rotates priority between winners so that no requester starves. It sits between a bank of request lines (interrupt sources, FIFO non-empty flags, port requests) and a single consumer that services one index at a time.

---
 rtl/prio_encoder_rr.sv | 77 +++++++
 tb/tb_prio_encoder_rr.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready output and
// optional round-robin search order starting after the last accepted winner.

module prio_encoder_rr_lane #(
  parameter int W    = 2,
  parameter int LANE = 0
) (
  input  logic         req,
  input  logic [W-1:0] start,
  output logic         hi
);
  assign hi = req && (W'(LANE) >= start);
endmodule

module prio_encoder_rr #(
  parameter int N  = 4,
  parameter int W  = $clog2(N),
  parameter int RR = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);

  logic [W-1:0] ptr, ptr_nxt, win;
  logic [N-1:0] hi, sel, onehot;
  logic         accept, load, any_req;

  assign accept  = out_valid && out_ready;
  assign load    = !out_valid || out_ready;
  assign any_req = |req;

  // The search starts from the post-accept pointer so back-to-back grants rotate.
  always_comb begin
    ptr_nxt = ptr;
    if (RR != 0 && accept)
      ptr_nxt = (out_idx == W'(N-1)) ? '0 : out_idx + W'(1);
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    prio_encoder_rr_lane #(.W(W), .LANE(i)) u_lane (
      .req   (req[i]),
      .start (ptr_nxt),
      .hi    (hi[i])
    );
  end

  // Requests at or above the start win first; otherwise wrap to the lowest.
  always_comb begin
    sel = (|hi) ? hi : req;
    win = '0;
    for (int i = N-1; i >= 0; i--)
      if (sel[i]) win = W'(i);
    onehot = N'(1) << win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= '0;
    end else begin
      if (load) begin
        out_valid  <= any_req;
        out_idx    <= any_req ? win : '0;
        out_onehot <= any_req ? onehot : '0;
      end
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: three instances (N=4 fixed, N=4 RR,
// N=5 RR), directed stimulus pushes expectations, monitors pop and compare.

module tb_prio_encoder_rr;

  typedef struct packed {
    logic        v;
    logic [7:0]  idx;
    logic [15:0] tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a [3];
  logic [4:0] req_a [3];
  logic       rdy_a [3];

  logic       ov0, ov1, ov2;
  logic [1:0] oi0, oi1;
  logic [2:0] oi2;
  logic [3:0] oh0, oh1;
  logic [4:0] oh2;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int   errors = 0;
  int   checks = 0;
  int   tag_n  = 0;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(4), .RR(0)) u_fix4 (
    .clk(clk), .rst(rst_a[0]), .req(req_a[0][3:0]), .out_ready(rdy_a[0]),
    .out_valid(ov0), .out_idx(oi0), .out_onehot(oh0));

  prio_encoder_rr #(.N(4), .RR(1)) u_rr4 (
    .clk(clk), .rst(rst_a[1]), .req(req_a[1][3:0]), .out_ready(rdy_a[1]),
    .out_valid(ov1), .out_idx(oi1), .out_onehot(oh1));

  prio_encoder_rr #(.N(5), .RR(1)) u_rr5 (
    .clk(clk), .rst(rst_a[2]), .req(req_a[2]), .out_ready(rdy_a[2]),
    .out_valid(ov2), .out_idx(oi2), .out_onehot(oh2));

  task automatic chk(input int d, input logic v, input logic [63:0] idx,
                     input logic [63:0] oh, input exp_t e);
    logic [63:0] eoh;
    eoh = e.v ? (64'd1 << e.idx) : 64'd0;
    checks++;
    if (v !== e.v || idx !== 64'(e.idx) || oh !== eoh) begin
      errors++;
      $display("FAIL dut%0d step%0d: got valid=%b idx=%0d onehot=%b, want valid=%b idx=%0d onehot=%b",
               d, e.tag, v, idx, oh, e.v, e.idx, eoh);
    end
  endtask

  // Monitors sample just after the edge that consumed each step's inputs.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin e0 = q0.pop_front(); chk(0, ov0, 64'(oi0), 64'(oh0), e0); end
    if (q1.size() > 0) begin e1 = q1.pop_front(); chk(1, ov1, 64'(oi1), 64'(oh1), e1); end
    if (q2.size() > 0) begin e2 = q2.pop_front(); chk(2, ov2, 64'(oi2), 64'(oh2), e2); end
  end

  task automatic step(input int d, input logic r, input logic [4:0] rq, input logic rd,
                      input logic ev, input int ei);
    exp_t e;
    @(negedge clk);
    rst_a[d] = r;
    req_a[d] = rq;
    rdy_a[d] = rd;
    e.v   = ev;
    e.idx = 8'(ei);
    e.tag = 16'(tag_n);
    tag_n++;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_a[d] = 1'b1;
      req_a[d] = '0;
      rdy_a[d] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) rst_a[d] = 1'b0;

    // reset with all requests pending, then first result after release
    step(1, 1, 5'b01111, 1, 0, 0);
    step(1, 1, 5'b01111, 1, 0, 0);
    step(1, 0, 5'b01111, 1, 1, 0);
    step(1, 0, 5'b01111, 1, 1, 1);

    // single hot, fixed priority
    step(0, 0, 5'b00001, 1, 1, 0);
    step(0, 0, 5'b00010, 1, 1, 1);
    step(0, 0, 5'b00100, 1, 1, 2);
    step(0, 0, 5'b01000, 1, 1, 3);
    step(0, 0, 5'b00000, 1, 0, 0);

    // fixed priority holds the lowest index
    for (int i = 0; i < 4; i++) step(0, 0, 5'b01010, 1, 1, 1);

    // round-robin over 1011 skips index 2
    step(1, 1, 5'b00000, 1, 0, 0);
    begin
      int seq [6] = '{0, 1, 3, 0, 1, 3};
      for (int i = 0; i < 6; i++) step(1, 0, 5'b01011, 1, 1, seq[i]);
    end

    // back-pressure: result held, req changes ignored, then alternation
    step(1, 1, 5'b00000, 1, 0, 0);
    step(1, 0, 5'b00110, 0, 1, 1);
    step(1, 0, 5'b00110, 0, 1, 1);
    step(1, 0, 5'b00110, 0, 1, 1);
    step(1, 0, 5'b01000, 0, 1, 1);
    step(1, 0, 5'b00001, 0, 1, 1);
    step(1, 0, 5'b00110, 1, 1, 2);
    step(1, 0, 5'b00110, 1, 1, 1);
    step(1, 0, 5'b00110, 1, 1, 2);
    step(1, 0, 5'b00110, 1, 1, 1);

    // N=5 wrap, then reset mid-stream restarts at index 0
    step(2, 1, 5'b00000, 1, 0, 0);
    step(2, 0, 5'b10001, 1, 1, 0);
    step(2, 0, 5'b10001, 1, 1, 4);
    step(2, 0, 5'b10001, 1, 1, 0);
    step(2, 0, 5'b10001, 1, 1, 4);
    step(2, 1, 5'b10001, 1, 0, 0);
    step(2, 0, 5'b10001, 1, 1, 0);
    step(2, 0, 5'b10001, 1, 1, 4);

    repeat (3) @(negedge clk);
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q0.size() + q1.size() + q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
